// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: fetches framebuffer words over the bus into a word FIFO and unpacks them into 8-bit pixels.
// Define VGA_FETCH_UNDERRUN_CNT_EN to build the saturating per-frame underrun counter.
module vga_pixel_fetch #(
    parameter logic [31:0] FB_BASE    = 32'h0000_0000,
    parameter int          H_VISIBLE  = 640,
    parameter int          V_VISIBLE  = 480,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk25MHz,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pixel_req,
    output logic [7:0]  pixel_out,
    output logic        underrun,
    output logic [15:0] underrun_count,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_master_ack,
    input  logic [31:0] bus_in
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
    localparam logic [16:0] WPF = 17'(H_VISIBLE * V_VISIBLE / 4);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state_q;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q, level_d;
    logic [1:0] byte_q;
    logic [16:0] count_q, count_d;
    logic [7:0] pixel_q;
    logic [31:0] addr_q;
    logic underrun_q, bus_req_q, restart_q;
    logic empty, acked, push, pop, starved;
    assign empty = level_q == '0;
    assign acked = state_q == REQ && bus_req_q && bus_master_ack;
    // A word acked after a restart belongs to the old frame and is dropped.
    assign push = acked && !restart_q && !frame_start;
    assign pop = pixel_req && !empty && !frame_start && byte_q == 2'd3;
    assign starved = pixel_req && empty && !frame_start;
    assign level_d = frame_start ? '0 : level_q + LW'(push) - LW'(pop);
    assign count_d = count_q + 17'd1;
    always_ff @(posedge clk25MHz)
        if (reset && push) mem_q[wr_q] <= bus_in;
    always_ff @(posedge clk25MHz) begin
        if (!reset) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            addr_q     <= FB_BASE;
            count_q    <= '0;
            restart_q  <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            byte_q     <= '0;
            pixel_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            level_q <= level_d;
            if (frame_start) begin
                wr_q       <= '0;
                rd_q       <= '0;
                byte_q     <= '0;
                underrun_q <= 1'b0;
                if (pixel_req) pixel_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pixel_req && !empty) begin
                    pixel_q <= mem_q[rd_q][{byte_q, 3'b000} +: 8];
                    byte_q  <= byte_q + 1'b1;
                    if (pop) rd_q <= rd_q + 1'b1;
                end
                if (starved) begin
                    pixel_q    <= '0;
                    underrun_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        addr_q  <= FB_BASE;
                        count_q <= '0;
                    end else if (level_q < FULL && count_q < WPF) state_q <= REQ;
                end
                REQ: begin
                    bus_req_q <= 1'b1;
                    if (frame_start) begin
                        count_q   <= '0;
                        restart_q <= 1'b1;
                    end
                    if (acked) begin
                        bus_req_q <= 1'b0;
                        restart_q <= 1'b0;
                        if (restart_q || frame_start) begin
                            addr_q  <= FB_BASE;
                            count_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            addr_q  <= addr_q + 32'd4;
                            count_q <= count_d;
                            state_q <= count_d == WPF ? DONE : IDLE;
                        end
                    end
                end
                DONE: begin
                    if (frame_start) begin
                        addr_q  <= FB_BASE;
                        count_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;
    always_ff @(posedge clk25MHz)
        if (!reset || frame_start) ucnt_q <= '0;
        else if (starved && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    assign underrun_count = ucnt_q;
`else
    assign underrun_count = 16'h0000;
`endif
    assign pixel_out = pixel_q;
    assign underrun  = underrun_q;
    assign bus_req   = bus_req_q;
    assign bus_addr  = addr_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed tables, corner sequences and random traffic against a byte-queue model.
module tb_vga_pixel_fetch;
    logic clk25MHz = 1'b0;
    logic reset = 1'b0;
    logic frame_start = 1'b0, pixel_req = 1'b0, bus_master_ack = 1'b0;
    logic [31:0] bus_in = '0;
    logic [7:0] pixel_out;
    logic underrun, bus_req;
    logic [15:0] underrun_count;
    logic [31:0] bus_addr;
    logic s_fs = 1'b0, s_pr = 1'b0, s_ack = 1'b0;
    logic [7:0] s_pix;
    logic s_und, s_req;
    logic [15:0] s_ucnt;
    logic [31:0] s_addr;
    int n_checks = 0, n_fail = 0, hs = 0;
    always #20 clk25MHz = ~clk25MHz;

    vga_pixel_fetch u_dut (
        .clk25MHz(clk25MHz), .reset(reset), .frame_start(frame_start), .pixel_req(pixel_req),
        .pixel_out(pixel_out), .underrun(underrun), .underrun_count(underrun_count),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_master_ack(bus_master_ack), .bus_in(bus_in)
    );
    vga_pixel_fetch #(.H_VISIBLE(8), .V_VISIBLE(2)) u_small (
        .clk25MHz(clk25MHz), .reset(reset), .frame_start(s_fs), .pixel_req(s_pr),
        .pixel_out(s_pix), .underrun(s_und), .underrun_count(s_ucnt),
        .bus_req(s_req), .bus_addr(s_addr), .bus_master_ack(s_ack), .bus_in(32'h1234_5678)
    );

    // Model: FIFO held as a queue of pending pixels; words in FIFO = ceil(pixels/4).
    localparam int WPF = 640 * 480 / 4;
    logic [7:0] mq[$];
    bit m_busy, m_req, m_disc, m_und;
    logic [31:0] m_addr;
    logic [7:0] m_pix;
    int m_cnt, m_ucnt;

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_req = 0; m_disc = 0; m_und = 0;
        m_addr = 0; m_pix = 0; m_cnt = 0; m_ucnt = 0; hs = 0;
    endtask

    task automatic model_step(input bit fs, input bit pr, input bit ack, input logic [31:0] din);
        int lvl = (mq.size() + 3) / 4;
        if (fs) begin
            if (pr) m_pix = 8'h00;
            m_und = 0; m_ucnt = 0;
        end else if (pr) begin
            if (mq.size() > 0) m_pix = mq.pop_front();
            else begin
                m_pix = 8'h00; m_und = 1;
                if (m_ucnt != 65535) m_ucnt++;
            end
        end
        if (fs) begin
            mq.delete(); m_cnt = 0;
            if (!m_busy) m_addr = 0;
        end
        if (m_busy) begin
            if (m_req && ack) begin
                if (m_disc || fs) begin m_addr = 0; m_cnt = 0; end
                else begin
                    for (int b = 0; b < 4; b++) mq.push_back(din[8*b +: 8]);
                    m_addr += 4; m_cnt++;
                end
                m_busy = 0; m_req = 0; m_disc = 0;
            end else begin
                m_req = 1;
                if (fs) m_disc = 1;
            end
        end else if (!fs && lvl < 8 && m_cnt < WPF) m_busy = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("bus_req", 32'(bus_req), 32'(m_req));
        chk("bus_addr", bus_addr, m_addr);
        chk("pixel_out", 32'(pixel_out), 32'(m_pix));
        chk("underrun", 32'(underrun), 32'(m_und));
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        chk("underrun_count", 32'(underrun_count), 32'(m_ucnt));
`else
        chk("underrun_count", 32'(underrun_count), 32'h0);
`endif
    endtask

    task automatic cycle(input bit fs, input bit pr, input bit ack, input logic [31:0] din);
        frame_start = fs; pixel_req = pr; bus_master_ack = ack; bus_in = din;
        if (bus_req && ack) hs++;
        @(posedge clk25MHz);
        model_step(fs, pr, ack, din);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int n, input bit ack);
        for (int i = 0; i < n; i++) begin
            reset = 1'b0; frame_start = 0; pixel_req = 1; bus_master_ack = ack; bus_in = 32'hFFFF_FFFF;
            @(posedge clk25MHz);
            model_reset();
            #1;
            check_all();
            chk("rst_bus_req", 32'(bus_req), 32'h0);
            chk("rst_bus_addr", bus_addr, 32'h0);
        end
        reset = 1'b1;
    endtask

    typedef struct {
        bit pr; bit ack; logic [31:0] din;
        bit bus_chk; bit exp_req; logic [31:0] exp_addr; logic [7:0] exp_pix;
    } vec_t;
    vec_t tab[10];

    initial begin
        logic [31:0] s_seen[$];
        int guard;
        tab[0] = '{0, 1, 32'h4433_2211, 1, 0, 32'd0, 8'h00};
        tab[1] = '{0, 1, 32'h4433_2211, 1, 1, 32'd0, 8'h00};
        tab[2] = '{0, 1, 32'h4433_2211, 1, 0, 32'd4, 8'h00};
        tab[3] = '{0, 1, 32'h4433_2211, 1, 0, 32'd4, 8'h00};
        tab[4] = '{0, 1, 32'h4433_2211, 1, 1, 32'd4, 8'h00};
        tab[5] = '{0, 1, 32'h4433_2211, 1, 0, 32'd8, 8'h00};
        tab[6] = '{1, 1, 32'h4433_2211, 0, 0, 32'd0, 8'h11};
        tab[7] = '{1, 1, 32'h4433_2211, 0, 0, 32'd0, 8'h22};
        tab[8] = '{1, 1, 32'h4433_2211, 0, 0, 32'd0, 8'h33};
        tab[9] = '{1, 1, 32'h4433_2211, 0, 0, 32'd0, 8'h44};
        do_reset(2, 0);
        // Prefill from reset: first requests at base then base+4.
        for (int i = 0; i < 6; i++) begin
            cycle(0, tab[i].pr, tab[i].ack, tab[i].din);
            chk("tab_req", 32'(bus_req), 32'(tab[i].exp_req));
            chk("tab_addr", bus_addr, tab[i].exp_addr);
            chk("tab_pix", 32'(pixel_out), 32'(tab[i].exp_pix));
        end
        for (int i = 0; i < 30; i++) cycle(0, 0, 1, 32'h4433_2211);
        chk("fill_words", hs, 8);
        chk("full_no_req", 32'(bus_req), 32'h0);
        // Small frame: exactly four words, then DONE until frame_start.
        s_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_req) s_seen.push_back(s_addr);
            cycle(0, 0, 1, 32'h4433_2211);
        end
        chk("small_reqs", s_seen.size(), 4);
        for (int i = 0; i < s_seen.size() && i < 4; i++) chk("small_addr", s_seen[i], 32'(4 * i));
        chk("small_done_idle", 32'(s_req), 32'h0);
        s_fs = 1'b1;
        cycle(0, 0, 1, 32'h4433_2211);
        s_fs = 1'b0;
        guard = 0;
        while (!s_req && guard < 10) begin cycle(0, 0, 1, 32'h4433_2211); guard++; end
        chk("small_restart_req", 32'(s_req), 32'h1);
        chk("small_restart_addr", s_addr, 32'h0);
        s_ack = 1'b0;
        // Unpack order and one word popped.
        for (int i = 6; i < 10; i++) begin
            cycle(0, tab[i].pr, tab[i].ack, tab[i].din);
            chk("unpack_pix", 32'(pixel_out), 32'(tab[i].exp_pix));
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h4433_2211);
        chk("refetch_count", hs, 9);
        chk("refetch_addr", bus_addr, 32'd36);
        // Drain with bus stalled, then underrun.
        guard = 0;
        while (mq.size() > 0 && guard < 64) begin cycle(0, 1, 0, 0); guard++; end
        chk("drained", mq.size(), 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        chk("und_pix", 32'(pixel_out), 32'h0);
        chk("und_flag", 32'(underrun), 32'h1);
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        chk("und_count", 32'(underrun_count), 32'd3);
`else
        chk("und_count", 32'(underrun_count), 32'd0);
`endif
        // frame_start during an outstanding request: acked word dropped.
        chk("pre_fs_req", 32'(bus_req), 32'h1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'hDEAD_BEEF);
        chk("fs_ack_addr", bus_addr, 32'h0);
        chk("fs_ack_req", 32'(bus_req), 32'h0);
        cycle(0, 1, 0, 0);
        chk("fs_flushed_pix", 32'(pixel_out), 32'h0);
        chk("fs_flushed_und", 32'(underrun), 32'h1);
        guard = 0;
        while (!bus_req && guard < 10) begin cycle(0, 0, 0, 0); guard++; end
        chk("fs_next_addr", bus_addr, 32'h0);
        cycle(0, 0, 1, 32'hA0B0_C0D0);
        cycle(0, 1, 0, 0);
        chk("fs_new_pix", 32'(pixel_out), 32'hD0);
        // frame_start with pixel_req: flush wins, no underrun.
        cycle(1, 1, 0, 0);
        chk("fs_pr_pix", 32'(pixel_out), 32'h0);
        chk("fs_pr_und", 32'(underrun), 32'h0);
        // Reset in the middle of a request; ack during reset ignored.
        guard = 0;
        while (!bus_req && guard < 10) begin cycle(0, 0, 0, 0); guard++; end
        cycle(0, 1, 0, 0);
        chk("pre_rst_req", 32'(bus_req), 32'h1);
        do_reset(2, 1);
        chk("rst_pix", 32'(pixel_out), 32'h0);
        chk("rst_und", 32'(underrun), 32'h0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(299) == 0, $urandom_range(99) < 75, $urandom_range(1) == 1, $urandom);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
